// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: line prefetch into a double-banked line buffer
// with strict priority over CPU pixel writes.
module vga_fb_arbiter #(
  parameter int unsigned H_ACTIVE_VIDEO = 640,
  parameter int unsigned V_ACTIVE_VIDEO = 480,
  parameter int unsigned ADDR_W         = $clog2(H_ACTIVE_VIDEO * V_ACTIVE_VIDEO)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic [9:0]        fetch_line,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [2:0]        cpu_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [2:0]        mem_wdata,
  input  logic [2:0]        mem_rdata,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [9:0]        lb_waddr,
  output logic [2:0]        lb_wdata,
  output logic              fetch_busy,
  output logic              fetch_overrun
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned PIXELS = H_ACTIVE_VIDEO * V_ACTIVE_VIDEO;
  // One extra bit so a power-of-two frame size still compares correctly
  localparam logic [ADDR_W:0] PIXELS_W = (ADDR_W + 1)'(PIXELS);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(H_ACTIVE_VIDEO - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state, state_d;
  logic [ADDR_W-1:0] base, base_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              bank, bank_d;
  logic              rd_valid, rd_valid_d;
  logic [CNT_W-1:0]  rd_idx, rd_idx_d;

  logic line_ok;
  logic addr_ok;

  assign line_ok = 32'(fetch_line) < V_ACTIVE_VIDEO;
  assign addr_ok = {1'b0, cpu_addr} < PIXELS_W;

  // State register and read-pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      cnt      <= '0;
      bank     <= 1'b0;
      rd_valid <= 1'b0;
      rd_idx   <= '0;
    end else begin
      state    <= state_d;
      base     <= base_d;
      cnt      <= cnt_d;
      bank     <= bank_d;
      rd_valid <= rd_valid_d;
      rd_idx   <= rd_idx_d;
    end
  end

  // Next-state logic and memory port mux; the CPU path is same-cycle
  always_comb begin
    state_d    = state;
    base_d     = base;
    cnt_d      = cnt;
    bank_d     = bank;
    rd_valid_d = 1'b0;
    rd_idx_d   = rd_idx;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    cpu_ready  = 1'b0;

    case (state)
      IDLE: begin
        if (fetch_start) begin
          if (line_ok) begin
            state_d = FETCH;
            bank_d  = ~bank;
            base_d  = ADDR_W'(ADDR_W'(fetch_line) * ADDR_W'(H_ACTIVE_VIDEO));
            cnt_d   = '0;
          end
        end else begin
          cpu_ready = 1'b1;
          if (cpu_valid && addr_ok) begin
            mem_addr  = cpu_addr;
            mem_we    = 1'b1;
            mem_wdata = cpu_data;
          end
        end
      end
      FETCH: begin
        mem_addr   = base + ADDR_W'(cnt);
        cnt_d      = cnt + CNT_W'(1);
        rd_valid_d = 1'b1;
        rd_idx_d   = cnt;
        if (cnt == LAST_PIX) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rst) begin
      cpu_ready = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  assign lb_we         = rd_valid & ~rst;
  assign lb_bank       = bank;
  assign lb_waddr      = rd_idx;
  assign lb_wdata      = rd_valid ? mem_rdata : 3'd0;
  assign fetch_busy    = (state != IDLE) & ~rst;
  assign fetch_overrun = fetch_start & (state != IDLE) & ~rst;

endmodule
